// File: rtl/rca_seq_pkg.sv
// rtl/rca_seq_pkg.sv - shared FSM encoding and byte width for the sequential ripple-carry adder
package rca_seq_pkg;

   localparam int BYTE_W = 8;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

endpackage

// File: rtl/rca_8bit.sv
// rtl/rca_8bit.sv - 8-bit ripple-carry adder built from full-adder cells
module rca_8bit (
   input  logic [7:0] a,
   input  logic [7:0] b,
   input  logic       cin,
   output logic [7:0] sum,
   output logic       cout
);

   logic [8:0] c;

   assign c[0] = cin;

   for (genvar i = 0; i < 8; i++) begin : g_fa
      assign sum[i]   = a[i] ^ b[i] ^ c[i];
      assign c[i + 1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
   end

   assign cout = c[8];

endmodule

// File: rtl/rca_seq_adder.sv
// rtl/rca_seq_adder.sv - byte-serial add/subtract through a single 8-bit ripple-carry adder
module rca_seq_adder
   import rca_seq_pkg::*;
#(
   parameter int NBYTES = 4
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [BYTE_W*NBYTES-1:0]   a,
   input  logic [BYTE_W*NBYTES-1:0]   b,
   input  logic                       cin,
   input  logic                       op,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [BYTE_W*NBYTES-1:0]   sum,
   output logic                       cout,
   output logic                       ovf,
   output logic                       busy
);

   localparam int W    = BYTE_W * NBYTES;
   localparam int IDXW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
   localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NBYTES - 1);

   state_t            state, state_nx;
   logic [W-1:0]      a_q, b_q, sum_q;
   logic [IDXW-1:0]   idx;
   logic              carry, cout_q, ovf_q;
   logic [BYTE_W-1:0] a_byte, b_byte, byte_sum;
   logic              byte_cout, accept, step, last;

   assign accept = in_valid & in_ready;
   assign step   = (state == ST_RUN);
   assign last   = (idx == LAST_IDX);

   always_comb begin
      a_byte = '0;
      b_byte = '0;
      for (int j = 0; j < NBYTES; j++) begin
         if (idx == IDXW'(j)) begin
            a_byte = a_q[j*BYTE_W +: BYTE_W];
            b_byte = b_q[j*BYTE_W +: BYTE_W];
         end
      end
   end

   rca_8bit u_byte_adder (
      .a    (a_byte),
      .b    (b_byte),
      .cin  (carry),
      .sum  (byte_sum),
      .cout (byte_cout)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= ST_IDLE;
      else        state <= state_nx;
   end

   always_comb begin
      state_nx  = state;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      busy      = 1'b1;
      case (state)
         ST_IDLE: begin
            busy     = 1'b0;
            in_ready = 1'b1;
            if (in_valid) state_nx = ST_RUN;
         end
         ST_RUN: begin
            if (last) state_nx = ST_DONE;
         end
         ST_DONE: begin
            out_valid = 1'b1;
            if (out_ready) state_nx = ST_IDLE;
         end
         default: state_nx = ST_IDLE;
      endcase
   end

   // Subtraction is A + ~B + 1, so the captured B is pre-inverted and carry seeded with 1.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_q    <= '0;
         b_q    <= '0;
         sum_q  <= '0;
         idx    <= '0;
         carry  <= 1'b0;
         cout_q <= 1'b0;
         ovf_q  <= 1'b0;
      end else if (accept) begin
         a_q   <= a;
         b_q   <= op ? ~b : b;
         idx   <= '0;
         carry <= op ? 1'b1 : cin;
      end else if (step) begin
         for (int j = 0; j < NBYTES; j++) begin
            if (idx == IDXW'(j)) sum_q[j*BYTE_W +: BYTE_W] <= byte_sum;
         end
         carry <= byte_cout;
         if (last) begin
            // Carry into the MSB is recovered from the MSB sum bit of the top byte.
            cout_q <= byte_cout;
            ovf_q  <= byte_cout ^ (a_byte[BYTE_W-1] ^ b_byte[BYTE_W-1] ^ byte_sum[BYTE_W-1]);
         end else begin
            idx <= idx + IDXW'(1);
         end
      end
   end

   assign sum  = sum_q;
   assign cout = cout_q;
   assign ovf  = ovf_q;

endmodule

// File: tb/tb_rca_seq_adder.sv
// tb/tb_rca_seq_adder.sv - scoreboard bench for rca_seq_adder with directed and random operands
module tb_rca_seq_adder;

   localparam int  NBYTES = 4;
   localparam int  W      = 8 * NBYTES;
   localparam time P      = 10;

   logic         clk = 1'b0;
   logic         rst_n = 1'b1;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic [W-1:0] a = '0;
   logic [W-1:0] b = '0;
   logic         cin = 1'b0;
   logic         op = 1'b0;
   logic         out_valid;
   logic         out_ready = 1'b0;
   logic [W-1:0] sum;
   logic         cout;
   logic         ovf;
   logic         busy;

   always #(P/2) clk = ~clk;

   rca_seq_adder #(.NBYTES(NBYTES)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .cin       (cin),
      .op        (op),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .sum       (sum),
      .cout      (cout),
      .ovf       (ovf),
      .busy      (busy)
   );

   typedef struct {
      logic [W-1:0] sum;
      logic         cout;
      logic         ovf;
      time          acc;
   } exp_t;

   exp_t sb[$];
   int   n_cmp = 0;
   int   n_bad = 0;
   bit   rand_ready = 1'b0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference: unsigned arithmetic for sum/carry, signed range test for overflow.
   function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y,
                                  input logic c, input logic o);
      exp_t    e;
      logic [W:0] u;
      longint  sx, sy, sr, maxv, minv;
      sx   = longint'($signed(x));
      sy   = longint'($signed(y));
      maxv = (longint'(1) << (W - 1)) - 1;
      minv = -(longint'(1) << (W - 1));
      if (!o) begin
         u      = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, c};
         sr     = sx + sy + longint'(c);
         e.cout = u[W];
      end else begin
         u      = {1'b0, x} - {1'b0, y};
         sr     = sx - sy;
         e.cout = (x >= y);
      end
      e.sum = u[W-1:0];
      e.ovf = (sr > maxv) || (sr < minv);
      e.acc = 0;
      return e;
   endfunction

   function automatic exp_t mk(input logic [W-1:0] s, input logic c, input logic v);
      exp_t e;
      e.sum  = s;
      e.cout = c;
      e.ovf  = v;
      e.acc  = 0;
      return e;
   endfunction

   task automatic issue(input logic [W-1:0] x, input logic [W-1:0] y, input logic c,
                        input logic o, input bit push, input exp_t e);
      int t;
      t = 0;
      @(negedge clk);
      a = x; b = y; cin = c; op = o; in_valid = 1'b1;
      while (!in_ready && t < 200) begin
         @(negedge clk);
         t++;
      end
      if (!in_ready) begin
         check("accept_timeout", 64'd0, 64'd1);
         in_valid = 1'b0;
         return;
      end
      @(posedge clk);
      if (push) begin
         e.acc = $time;
         sb.push_back(e);
      end
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic send(input logic [W-1:0] x, input logic [W-1:0] y, input logic c, input logic o);
      issue(x, y, c, o, 1'b1, model(x, y, c, o));
   endtask

   task automatic wait_idle();
      int t;
      t = 0;
      while ((sb.size() != 0 || !in_ready) && t < 500) begin
         @(negedge clk);
         t++;
      end
      if (sb.size() != 0 || !in_ready) check("drain_timeout", 64'd0, 64'd1);
   endtask

   initial begin
      bit seen;
      seen = 1'b0;
      forever begin
         @(negedge clk);
         #1;
         if (!rst_n) begin
            seen = 1'b0;
         end else if (out_valid) begin
            if (sb.size() == 0) begin
               check("unexpected_result", 64'd1, 64'd0);
            end else begin
               if (!seen) begin
                  check("latency", 64'($time - sb[0].acc), 64'(NBYTES*P + P/2 + 1));
                  seen = 1'b1;
               end
               if (out_ready) begin
                  check("sum", 64'(sum), 64'(sb[0].sum));
                  check("cout", 64'(cout), 64'(sb[0].cout));
                  check("ovf", 64'(ovf), 64'(sb[0].ovf));
                  void'(sb.pop_front());
                  seen = 1'b0;
               end
            end
         end
      end
   end

   initial begin
      forever begin
         @(negedge clk);
         if (rand_ready) out_ready = 1'($urandom_range(0, 1));
      end
   end

   initial begin
      #(P * 100000);
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

   initial begin
      int t;
      logic [W-1:0] x, y;

      rst_n = 1'b0;
      #1;
      check("rst_in_ready", 64'(in_ready), 64'd1);
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_sum", 64'(sum), 64'd0);
      check("rst_cout", 64'(cout), 64'd0);
      check("rst_ovf", 64'(ovf), 64'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      out_ready = 1'b1;

      issue(32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, 1'b1, mk(32'h0000_0100, 1'b0, 1'b0));
      wait_idle();
      issue(32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, 1'b1, mk(32'h0000_0000, 1'b1, 1'b0));
      issue(32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, 1'b1, mk(32'hFFFF_FFFE, 1'b0, 1'b0));
      issue(32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 1'b1, mk(32'h7FFF_FFFF, 1'b1, 1'b1));
      wait_idle();

      // Backpressure: result held in DONE while new requests are refused.
      out_ready = 1'b0;
      issue(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 1'b1, mk(32'h8000_0000, 1'b0, 1'b1));
      t = 0;
      while (!out_valid && t < 50) begin
         @(negedge clk);
         t++;
      end
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         in_valid = (k % 2 == 0);
         a = $urandom;
         b = $urandom;
         #1;
         check("bp_sum", 64'(sum), 64'h8000_0000);
         check("bp_cout", 64'(cout), 64'd0);
         check("bp_ovf", 64'(ovf), 64'd1);
         check("bp_in_ready", 64'(in_ready), 64'd0);
         check("bp_out_valid", 64'(out_valid), 64'd1);
      end
      @(negedge clk);
      in_valid = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      #2;
      check("bp_idle_in_ready", 64'(in_ready), 64'd1);
      check("bp_idle_busy", 64'(busy), 64'd0);
      wait_idle();

      // Reset after two bytes of an operation aborts it.
      issue(32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0, 1'b0, mk('0, 1'b0, 1'b0));
      @(posedge clk);
      @(posedge clk);
      #1;
      check("rm_partial_sum", 64'(sum[15:0]), 64'h6789);
      rst_n = 1'b0;
      #1;
      check("rm_out_valid", 64'(out_valid), 64'd0);
      check("rm_busy", 64'(busy), 64'd0);
      check("rm_sum", 64'(sum), 64'd0);
      check("rm_cout", 64'(cout), 64'd0);
      check("rm_in_ready", 64'(in_ready), 64'd1);
      @(negedge clk);
      rst_n = 1'b1;
      issue(32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0, 1'b1, mk(32'h2345_6789, 1'b0, 1'b0));
      wait_idle();

      for (int i = 0; i < W; i++) begin
         for (int c = 0; c < 2; c++) begin
            x = 32'd1 << i;
            send(x, '0, 1'(c), 1'b0);
            send('0, x, 1'(c), 1'b0);
         end
      end
      wait_idle();

      rand_ready = 1'b1;
      for (int n = 0; n < 200; n++) begin
         x = $urandom;
         y = $urandom;
         case ($urandom_range(0, 5))
            0: x = 32'hFFFF_FFFF;
            1: y = 32'h8000_0000;
            2: x = 32'h7FFF_FFFF;
            default: ;
         endcase
         send(x, y, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end
      rand_ready = 1'b0;
      @(negedge clk);
      out_ready = 1'b1;
      wait_idle();

      check("sb_empty", 64'(sb.size()), 64'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
